// File: rtl/ibr_stream_wrapper.sv
// CSR front end for the IBR block-cipher core: two block FIFOs around
// a sequencer that hands one block at a time to the core.
module ibr_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_ok) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

module ibr_stream_wrapper #(
    parameter int BLOCK_W    = 128,
    parameter int KEY_W      = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               Clk,
    input  logic               RstN,
    input  logic               CS,
    input  logic               Write,
    input  logic               Read,
    input  logic [4:0]         Addr,
    input  logic [31:0]        WData,
    output logic [31:0]        RData,
    output logic               core_Enable,
    output logic               core_SA,
    output logic               core_Encrypt,
    output logic [1:0]         core_SOM,
    output logic               core_FB,
    output logic [63:0]        core_key0,
    output logic [63:0]        core_key1,
    output logic [BLOCK_W-1:0] core_IV,
    output logic [BLOCK_W-1:0] core_plainText,
    input  logic [BLOCK_W-1:0] core_cipherText,
    input  logic               core_cipherReady
);
    localparam int NW = BLOCK_W / 32;
    localparam int IW = $clog2(NW);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;
    state_t state_q;

    logic             en_q, enc_q, fb_q, sa_pend_q;
    logic [1:0]       som_q;
    logic [31:0]      key_q [4];
    logic [31:0]      iv_q [NW];
    logic [31:0]      din_q [NW-1];
    logic             in_ovf_q, out_udf_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             cen_q, csa_q, cenc_q, cfb_q;
    logic [1:0]       csom_q;
    logic [KEY_W-1:0] ckey_q;
    logic [BLOCK_W-1:0] civ_q, cpt_q, res_q;

    logic wr, rd, clr;
    logic sel_ctrl, sel_stat, sel_key, sel_iv, sel_din, sel_dout;
    logic [1:0]    key_idx;
    logic [IW-1:0] iv_idx, blk_idx;
    logic          last_word, in_push, out_pop;
    logic [BLOCK_W-1:0] in_blk, iv_cat, in_head, out_head;
    logic          in_full, in_empty, out_full, out_empty;
    logic [CW-1:0] in_cnt, out_cnt;
    logic [31:0]   status;

    assign wr        = CS && Write;
    assign rd        = CS && Read && !Write;
    assign sel_ctrl  = (Addr == 5'd0);
    assign sel_stat  = (Addr == 5'd1);
    assign sel_key   = (Addr >= 5'd2) && (Addr <= 5'd5);
    assign sel_iv    = (Addr >= 5'd6) && (Addr < 5'(6 + NW));
    assign sel_din   = (Addr >= 5'h10) && (Addr < 5'(16 + NW));
    assign sel_dout  = (Addr >= 5'h18) && (Addr < 5'(24 + NW));
    assign key_idx   = Addr[1:0] - 2'd2;
    assign iv_idx    = Addr[IW-1:0] - IW'(6);
    assign blk_idx   = Addr[IW-1:0];
    assign last_word = (blk_idx == IW'(NW - 1));
    assign clr       = wr && sel_ctrl && WData[5];
    assign in_push   = wr && sel_din && last_word;
    assign out_pop   = rd && sel_dout && last_word;

    always_comb begin
        in_blk = '0;
        iv_cat = '0;
        for (int i = 0; i < NW - 1; i++) in_blk[i*32 +: 32] = din_q[i];
        in_blk[BLOCK_W-1 -: 32] = WData;
        for (int i = 0; i < NW; i++) iv_cat[i*32 +: 32] = iv_q[i];
    end

    ibr_fifo #(.W(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk_i(Clk), .rst_ni(RstN), .clr_i(clr),
        .push_i(in_push), .din_i(in_blk), .pop_i(state_q == ISSUE),
        .head_o(in_head), .full_o(in_full), .empty_o(in_empty),
        .count_o(in_cnt)
    );

    ibr_fifo #(.W(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk_i(Clk), .rst_ni(RstN), .clr_i(clr),
        .push_i(state_q == STORE), .din_i(res_q), .pop_i(out_pop),
        .head_o(out_head), .full_o(out_full), .empty_o(out_empty),
        .count_o(out_cnt)
    );

    always_comb begin
        status        = '0;
        status[0]     = in_full;
        status[1]     = in_empty;
        status[2]     = out_full;
        status[3]     = out_empty;
        status[4]     = (state_q != IDLE);
        status[5]     = in_ovf_q;
        status[6]     = out_udf_q;
        status[15:8]  = 8'(in_cnt);
        status[23:16] = 8'(out_cnt);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            unique case (1'b1)
                sel_ctrl: rdata_d = {27'b0, fb_q, som_q, enc_q, en_q};
                sel_stat: rdata_d = status;
                sel_key:  rdata_d = key_q[key_idx];
                sel_iv:   rdata_d = iv_q[iv_idx];
                sel_dout: rdata_d = out_empty ? '0 : out_head[32*blk_idx +: 32];
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            en_q      <= 1'b0;
            enc_q     <= 1'b0;
            som_q     <= '0;
            fb_q      <= 1'b0;
            sa_pend_q <= 1'b0;
            in_ovf_q  <= 1'b0;
            out_udf_q <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < 4; i++) key_q[i] <= '0;
            for (int i = 0; i < NW; i++) iv_q[i] <= '0;
            for (int i = 0; i < NW - 1; i++) din_q[i] <= '0;
        end else begin
            rdata_q <= rdata_d;
            if (wr && sel_ctrl) begin
                en_q  <= WData[0];
                enc_q <= WData[1];
                som_q <= WData[3:2];
                fb_q  <= WData[4];
            end
            if (wr && sel_key) key_q[key_idx] <= WData;
            if (wr && sel_iv) iv_q[iv_idx] <= WData;
            if (wr && sel_din && !last_word) din_q[blk_idx] <= WData;
            // SA marks the first block after EN rises or after a clear
            if (clr || (wr && sel_ctrl && WData[0] && !en_q))
                sa_pend_q <= 1'b1;
            else if (state_q == ISSUE)
                sa_pend_q <= 1'b0;
            if (in_push && in_full)
                in_ovf_q <= 1'b1;
            else if (wr && sel_stat && WData[5])
                in_ovf_q <= 1'b0;
            if (out_pop && out_empty)
                out_udf_q <= 1'b1;
            else if (wr && sel_stat && WData[6])
                out_udf_q <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            cen_q   <= 1'b0;
            csa_q   <= 1'b0;
            cenc_q  <= 1'b0;
            csom_q  <= '0;
            cfb_q   <= 1'b0;
            ckey_q  <= '0;
            civ_q   <= '0;
            cpt_q   <= '0;
            res_q   <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            cen_q   <= 1'b0;
            csa_q   <= 1'b0;
        end else begin
            cen_q <= 1'b0;
            csa_q <= 1'b0;
            unique case (state_q)
                IDLE: if (en_q && !in_empty && !out_full) state_q <= ISSUE;
                ISSUE: begin
                    cpt_q   <= in_head;
                    ckey_q  <= {key_q[3], key_q[2], key_q[1], key_q[0]};
                    civ_q   <= iv_cat;
                    cenc_q  <= enc_q;
                    csom_q  <= som_q;
                    cfb_q   <= fb_q;
                    cen_q   <= 1'b1;
                    csa_q   <= sa_pend_q;
                    state_q <= WAIT;
                end
                WAIT: if (core_cipherReady) begin
                    res_q   <= core_cipherText;
                    state_q <= STORE;
                end
                STORE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RData          = rdata_q;
    assign core_Enable    = cen_q;
    assign core_SA        = csa_q;
    assign core_Encrypt   = cenc_q;
    assign core_SOM       = csom_q;
    assign core_FB        = cfb_q;
    assign core_key0      = ckey_q[63:0];
    assign core_key1      = ckey_q[KEY_W-1:64];
    assign core_IV        = civ_q;
    assign core_plainText = cpt_q;
endmodule

// File: tb/tb_ibr_stream_wrapper.sv
// Scoreboard bench for ibr_stream_wrapper with an XOR core model
// of three-cycle latency.
module tb_ibr_stream_wrapper;
    logic         Clk = 1'b0;
    logic         RstN;
    logic         CS, Write, Read;
    logic [4:0]   Addr;
    logic [31:0]  WData, RData;
    logic         core_Enable, core_SA, core_Encrypt, core_FB;
    logic [1:0]   core_SOM;
    logic [63:0]  core_key0, core_key1;
    logic [127:0] core_IV, core_plainText, core_cipherText;
    logic         core_cipherReady;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rexp_t;
    typedef struct {
        string       name;
        logic        sa;
        logic [3:0]  cfg;
        logic [31:0] pt;
    } eexp_t;
    rexp_t rq[$];
    eexp_t eq[$];

    localparam logic [31:0] KW = 32'h0F0F_0F0F;

    ibr_stream_wrapper dut (
        .Clk(Clk), .RstN(RstN), .CS(CS), .Write(Write), .Read(Read),
        .Addr(Addr), .WData(WData), .RData(RData),
        .core_Enable(core_Enable), .core_SA(core_SA),
        .core_Encrypt(core_Encrypt), .core_SOM(core_SOM),
        .core_FB(core_FB), .core_key0(core_key0), .core_key1(core_key1),
        .core_IV(core_IV), .core_plainText(core_plainText),
        .core_cipherText(core_cipherText),
        .core_cipherReady(core_cipherReady)
    );

    always #5 Clk = ~Clk;

    logic         v1, v2, v3;
    logic [127:0] d1, d2, d3;
    always @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            {v1, v2, v3} <= '0;
            {d1, d2, d3} <= '0;
        end else begin
            v1 <= core_Enable;
            d1 <= core_plainText ^ {core_key1, core_key0};
            v2 <= v1;
            d2 <= d1;
            v3 <= v2;
            d3 <= d2;
        end
    end
    assign core_cipherReady = v3;
    assign core_cipherText  = d3;

    task automatic check(input string n, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    logic rd_seen;
    always @(posedge Clk or negedge RstN) begin
        if (!RstN) rd_seen <= 1'b0;
        else       rd_seen <= CS && Read && !Write;
    end

    always @(negedge Clk) begin
        rexp_t r;
        eexp_t e;
        if (RstN && rd_seen) begin
            if (rq.size() == 0) check("unexpected_read", 1'b1, 1'b0);
            else begin
                r = rq.pop_front();
                check(r.name, RData, r.val);
            end
        end
        if (RstN && core_Enable) begin
            if (eq.size() == 0) check("unexpected_enable", 1'b1, 1'b0);
            else begin
                e = eq.pop_front();
                check({e.name, "_sa"}, core_SA, e.sa);
                check({e.name, "_cfg"},
                      {core_Encrypt, core_SOM, core_FB}, e.cfg);
                check({e.name, "_pt"}, core_plainText[31:0], e.pt);
            end
        end
    end

    task automatic bw(input logic [4:0] a, input logic [31:0] d);
        CS = 1'b1; Write = 1'b1; Read = 1'b0; Addr = a; WData = d;
        @(negedge Clk);
        CS = 1'b0; Write = 1'b0;
    endtask

    task automatic br(input logic [4:0] a, input logic [31:0] e,
                      input string n);
        rq.push_back('{n, e});
        CS = 1'b1; Read = 1'b1; Write = 1'b0; Addr = a;
        @(negedge Clk);
        CS = 1'b0; Read = 1'b0;
    endtask

    task automatic push_blk(input logic [31:0] w);
        for (int i = 0; i < 4; i++) bw(5'h10 + 5'(i), w);
    endtask

    task automatic pop_blk(input logic [31:0] w, input string n);
        for (int i = 0; i < 4; i++) br(5'h18 + 5'(i), w, n);
    endtask

    task automatic expect_en(input string n, input logic sa,
                             input logic [3:0] cfg, input logic [31:0] pt);
        eq.push_back('{n, sa, cfg, pt});
    endtask

    function automatic logic outs_any();
        return |{RData, core_Enable, core_SA, core_Encrypt, core_SOM,
                 core_FB, core_key0, core_key1, core_IV, core_plainText};
    endfunction

    initial begin
        RstN = 1'b0; CS = 1'b0; Write = 1'b0; Read = 1'b0;
        Addr = '0; WData = '0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", outs_any(), 1'b0);
        RstN = 1'b1;
        @(negedge Clk);

        br(5'h01, 32'h0000_000A, "reset_status");
        br(5'h00, 32'h0, "reset_ctrl");
        br(5'h18, 32'h0, "reset_dout");

        for (int i = 0; i < 4; i++) bw(5'd2 + 5'(i), KW);
        br(5'h03, KW, "key_readback");
        push_blk(32'h1111_1111);
        br(5'h01, 32'h0000_0108, "one_queued");
        expect_en("blk1", 1'b1, 4'b1101, 32'h1111_1111);
        bw(5'h00, 32'h0000_001B);
        br(5'h00, 32'h0000_001B, "ctrl_readback");
        repeat (10) @(negedge Clk);
        br(5'h01, 32'h0001_0002, "one_result");
        pop_blk(32'h1E1E_1E1E, "dout_blk1");
        br(5'h01, 32'h0000_000A, "after_pop1");

        bw(5'h00, 32'h0);
        for (int i = 0; i < 4; i++) push_blk(32'hA000_0000 | 32'(i));
        br(5'h01, 32'h0000_0409, "in_full");
        push_blk(32'hDEAD_BEEF);
        br(5'h01, 32'h0000_0429, "in_ovf");

        for (int i = 0; i < 4; i++)
            expect_en("burst", i == 0, 4'b0000, 32'hA000_0000 | 32'(i));
        bw(5'h00, 32'h0000_0001);
        repeat (40) @(negedge Clk);
        br(5'h01, 32'h0004_0026, "out_full");
        expect_en("blk5", 1'b0, 4'b0000, 32'hB5B5_B5B5);
        push_blk(32'hB5B5_B5B5);
        repeat (4) @(negedge Clk);
        br(5'h01, 32'h0004_0124, "held_by_out_full");
        pop_blk(32'hA000_0000 ^ KW, "dout_burst0");
        repeat (12) @(negedge Clk);
        br(5'h01, 32'h0004_0026, "refilled");
        for (int i = 1; i < 4; i++)
            pop_blk((32'hA000_0000 | 32'(i)) ^ KW, "dout_burst");
        pop_blk(32'hB5B5_B5B5 ^ KW, "dout_blk5");
        br(5'h01, 32'h0000_002A, "drained");

        br(5'h1B, 32'h0, "underflow_data");
        br(5'h01, 32'h0000_006A, "out_udf_set");
        bw(5'h01, 32'h0000_0040);
        br(5'h01, 32'h0000_002A, "out_udf_clr");
        bw(5'h01, 32'h0000_0020);
        br(5'h01, 32'h0000_000A, "in_ovf_clr");

        expect_en("pre_clr", 1'b0, 4'b0000, 32'hC0C0_C0C0);
        push_blk(32'hC0C0_C0C0);
        repeat (2) @(negedge Clk);
        bw(5'h00, 32'h0000_0021);
        repeat (8) @(negedge Clk);
        br(5'h01, 32'h0000_000A, "clr_dropped");
        br(5'h00, 32'h0000_0001, "clr_self_clear");
        expect_en("post_clr", 1'b1, 4'b0000, 32'hD0D0_D0D0);
        push_blk(32'hD0D0_D0D0);
        repeat (10) @(negedge Clk);
        pop_blk(32'hDFDF_DFDF, "dout_post_clr");

        expect_en("pre_rst", 1'b0, 4'b0000, 32'hE0E0_E0E0);
        push_blk(32'hE0E0_E0E0);
        repeat (3) @(negedge Clk);
        RstN = 1'b0;
        repeat (2) @(negedge Clk);
        check("midrun_reset_outputs", outs_any(), 1'b0);
        RstN = 1'b1;
        br(5'h01, 32'h0000_000A, "post_reset_status");
        br(5'h00, 32'h0, "post_reset_ctrl");
        repeat (8) @(negedge Clk);
        br(5'h01, 32'h0000_000A, "post_reset_quiet");
        repeat (2) @(negedge Clk);

        check("reads_pending", 32'(rq.size()), 32'd0);
        check("enables_pending", 32'(eq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
